zbt_point_writer: RTL
=====================

Name: zbt_point_writer

Overview:
- Write-side counterpart of the point renderer: accepts a stream of (x,y,z) scan points and packs each into a 36-bit ZBT word.
- Writes points to consecutive ZBT0 addresses starting at 0, then publishes max_zbt_addr so the renderer sweeps exactly the captured frame.
- Sits between the scan/triangulation pipeline and the ZBT0 controller write port.
- A small internal FIFO absorbs cycles where the ZBT write port is not granted.

Parameters:
FIFO_DEPTH, 4, entries in point buffer (power of 2, >=2)
ADDR_W, 19, ZBT address width
Z_MIN, 10'd0, lower z bound (used only with DEPTH_CLIP_EN)
Z_MAX, 10'd1023, upper z bound (used only with DEPTH_CLIP_EN)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
start  input  1  pulse: clear and begin frame capture
finish  input  1  pulse: end of frame, flush buffer
pt_valid  input  1  point valid
pt_ready  output  1  point accepted when pt_valid&pt_ready
pt_x  input  10  point x
pt_y  input  10  point y
pt_z  input  10  point depth
wr_grant  input  1  ZBT0 write port available this cycle
zbt0_write_addr  output  19  write address
zbt0_write_data  output  36  packed word
zbt0_we  output  1  write strobe
max_zbt_addr  output  19  last valid address of committed frame
point_count  output  20  points written in current/last frame
busy  output  1  high in CAPTURE/FLUSH
done  output  1  one-cycle pulse on frame commit
overflow  output  1  sticky: points dropped because address space is full

Behaviour:
- Reset: all outputs 0, state IDLE, FIFO empty.
- Packing: data[35:30]=0, [29:20]=x, [19:10]=y, [9:0]=z.
- States:
  - IDLE: pt_ready=0. start -> CAPTURE.
  - CAPTURE: pt_ready=!fifo_full. finish -> FLUSH.
  - FLUSH: pt_ready=0. Drain FIFO; go to DONE when FIFO is empty and no write is pending.
  - DONE: done=1 for one cycle, then -> IDLE.
- Entering CAPTURE: clear FIFO, write address, point_count and overflow in the same edge.
- start in any state restarts capture; start wins over a simultaneous finish. finish outside CAPTURE is ignored.
- Write path: when FIFO is non-empty and wr_grant=1, pop the head and register addr/data with zbt0_we=1 on the next edge. zbt0_we is high exactly one cycle per pop. Addr then increments and point_count increments.
- Latency: a point accepted at edge N reaches zbt0_we=1 at the earliest after edge N+1 (grant high).
- Order is preserved. No point is lost while the FIFO has space.
- wr_grant=0 holds zbt0_we=0 and the FIFO contents.
- A push on a full FIFO is impossible (pt_ready=0). Simultaneous push and pop on a non-full FIFO keeps occupancy unchanged.
- Address exhaustion: once address 2^ADDR_W-1 has been written, overflow=1 (sticky until next start). Later pops are discarded with no zbt0_we, and the count saturates.
- max_zbt_addr holds the previous frame's value throughout capture, so the renderer stays coherent. It updates only at DONE: count==0 ? 0 : count-1.
- Reset mid-operation: immediate return to IDLE; max_zbt_addr=0.

Optional Feature:
DEPTH_CLIP_EN
- Defined: accepted points with z<Z_MIN or z>Z_MAX are consumed (pt_ready unaffected) but never written or counted.
- Undefined: every accepted point is written, and Z_MIN/Z_MAX are unused.

Decomposition:
- Shared package zbt_pkg holds:
  - field offsets X_LSB=20, Y_LSB=10, Z_LSB=0
  - field width 10, word width 36, ADDR_W
  - state encodings IDLE/CAPTURE/FLUSH/DONE
- One sub-module: point_fifo (synchronous FIFO, async reset, full/empty flags). The top level holds the FSM, clipping, write register and counters.

Test Plan:
- Burst with grant always high:
  - stimulus: start, 3 points (1,2,3),(4,5,6),(7,8,9), finish
  - response: we at addr 0,1,2 with data {6'b0,x,y,z}; done pulse; max_zbt_addr=2, point_count=3.
- Grant gating:
  - stimulus: grant low for 10 cycles while 6 points are offered
  - response: pt_ready drops after 4 accepts; grant high writes all 6 in order; no loss.
- Empty frame:
  - stimulus: start then finish with no points
  - response: done; max_zbt_addr=0, point_count=0.
- Frame coherence and restart:
  - stimulus: previous frame max=2; new capture of 5 points
  - response: max_zbt_addr stays 2 until done, then becomes 4.
  - stimulus: start during FLUSH
  - response: counters clear and addr restarts at 0.
- Overflow:
  - stimulus: force addr to 2^19-2 via a long run, then write 3 points
  - response: two writes complete; overflow=1; third point produces no we.
- Reset and clipping:
  - stimulus: async reset mid-CAPTURE
  - response: all outputs 0 immediately.
  - stimulus: with DEPTH_CLIP_EN, Z_MIN=100, points z=50,200
  - response: only z=200 point written, at addr 0.

Source files
------------

// File: rtl/zbt_pkg.sv
// Shared field layout, widths and FSM state encoding for the ZBT point writer.
package zbt_pkg;

   localparam int FIELD_W    = 10;
   localparam int WORD_W     = 36;
   localparam int ZBT_ADDR_W = 19;
   localparam int X_LSB      = 20;
   localparam int Y_LSB      = 10;
   localparam int Z_LSB      = 0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_FLUSH   = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   function automatic logic [WORD_W-1:0] pack_point(
      input logic [FIELD_W-1:0] x,
      input logic [FIELD_W-1:0] y,
      input logic [FIELD_W-1:0] z
   );
      logic [WORD_W-1:0] w;
      w = '0;
      w[X_LSB +: FIELD_W] = x;
      w[Y_LSB +: FIELD_W] = y;
      w[Z_LSB +: FIELD_W] = z;
      return w;
   endfunction

endpackage

// File: rtl/zbt_point_writer_fifo.sv
// Small synchronous point buffer with async reset, synchronous clear and full/empty flags.
module point_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 30
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PW:0]       wr_ptr_q;
   logic [PW:0]       rd_ptr_q;
   logic              do_push;
   logic              do_pop;

   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign full_o    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign rd_data_o = mem_q[rd_ptr_q[PW-1:0]];
   assign do_push   = push_i && !full_o && !clear_i;
   assign do_pop    = pop_i && !empty_o && !clear_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   // Storage is not reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= wr_data_i;
   end

endmodule

// File: rtl/zbt_point_writer.sv
// Packs (x,y,z) scan points into 36-bit ZBT words written to consecutive addresses.
// Optional depth clipping of points outside [Z_MIN, Z_MAX] is enabled by DEPTH_CLIP_EN.
//
// state   | meaning
// IDLE    | waiting for start, no points accepted
// CAPTURE | accepting points and writing them out as the port is granted
// FLUSH   | frame ended, draining buffered points
// DONE    | frame committed, max_zbt_addr updated, done pulse
module zbt_point_writer
   import zbt_pkg::*;
#(
   parameter int                 FIFO_DEPTH = 4,
   parameter int                 ADDR_W     = ZBT_ADDR_W,
   parameter logic [FIELD_W-1:0] Z_MIN      = 10'd0,
   parameter logic [FIELD_W-1:0] Z_MAX      = 10'd1023
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               finish,
   input  logic               pt_valid,
   output logic               pt_ready,
   input  logic [FIELD_W-1:0] pt_x,
   input  logic [FIELD_W-1:0] pt_y,
   input  logic [FIELD_W-1:0] pt_z,
   input  logic               wr_grant,
   output logic [ADDR_W-1:0]  zbt0_write_addr,
   output logic [WORD_W-1:0]  zbt0_write_data,
   output logic               zbt0_we,
   output logic [ADDR_W-1:0]  max_zbt_addr,
   output logic [ADDR_W:0]    point_count,
   output logic               busy,
   output logic               done,
   output logic               overflow
);

   localparam int PT_W = 3 * FIELD_W;
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   state_t              state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [WORD_W-1:0]   wr_data_q;
   logic                we_q;
   logic [ADDR_W-1:0]   max_q;
   logic [ADDR_W:0]     count_q;
   logic [ADDR_W:0]     count_m1;
   logic                busy_q;
   logic                done_q;
   logic                ovf_q;

   logic                z_ok;
   logic                fifo_push;
   logic                fifo_pop;
   logic                fifo_full;
   logic                fifo_empty;
   logic [PT_W-1:0]     fifo_head;

`ifdef DEPTH_CLIP_EN
   assign z_ok = (pt_z >= Z_MIN) && (pt_z <= Z_MAX);
`else
   logic unused_zbounds;
   assign unused_zbounds = ^{Z_MIN, Z_MAX};
   assign z_ok = 1'b1;
`endif

   assign pt_ready  = (state_q == ST_CAPTURE) && !fifo_full;
   // Clipped points are still handshaken, just never enter the buffer.
   assign fifo_push = pt_valid && pt_ready && z_ok;
   assign fifo_pop  = ((state_q == ST_CAPTURE) || (state_q == ST_FLUSH)) &&
                      !fifo_empty && wr_grant && !start;
   assign count_m1  = count_q - COUNT_ONE;

   point_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (PT_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (reset),
      .clear_i   (start),
      .push_i    (fifo_push),
      .wr_data_i ({pt_x, pt_y, pt_z}),
      .pop_i     (fifo_pop),
      .rd_data_o (fifo_head),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         we_q      <= 1'b0;
         max_q     <= '0;
         count_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         we_q   <= 1'b0;
         done_q <= 1'b0;
         if (start) begin
            state_q <= ST_CAPTURE;
            busy_q  <= 1'b1;
            addr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
         end else begin
            unique case (state_q)
               ST_IDLE: ;
               ST_CAPTURE: begin
                  if (finish) state_q <= ST_FLUSH;
               end
               ST_FLUSH: begin
                  if (fifo_empty) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     max_q   <= (count_q == '0) ? '0 : count_m1[ADDR_W-1:0];
                  end
               end
               ST_DONE: state_q <= ST_IDLE;
               default: state_q <= ST_IDLE;
            endcase

            // Once the top address is used, further pops are dropped silently.
            if (fifo_pop && !ovf_q) begin
               we_q      <= 1'b1;
               wr_addr_q <= addr_q;
               wr_data_q <= pack_point(fifo_head[2*FIELD_W +: FIELD_W],
                                       fifo_head[FIELD_W +: FIELD_W],
                                       fifo_head[0 +: FIELD_W]);
               addr_q    <= addr_q + ADDR_ONE;
               count_q   <= count_q + COUNT_ONE;
               if (&addr_q) ovf_q <= 1'b1;
            end
         end
      end
   end

   assign zbt0_write_addr = wr_addr_q;
   assign zbt0_write_data = wr_data_q;
   assign zbt0_we         = we_q;
   assign max_zbt_addr    = max_q;
   assign point_count     = count_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign overflow        = ovf_q;

endmodule
